// File: rtl/mx_rx_pkg.sv
// mx_rx_pkg: shared state type and default timing constants for the Manchester frame receiver
package mx_rx_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
  localparam int DEF_SPB     = 16;
  localparam int DEF_WIN     = 2;
  localparam int DEF_SYNC_TO = 160;
endpackage

// File: rtl/mx_bit_timer.sv
// mx_bit_timer: enb tick counter with decision-window and overrun compare against the tick being taken
module mx_bit_timer #(
  parameter int SPB     = 16,
  parameter int WIN     = 2,
  parameter int SYNC_TO = 160,
  parameter int W       = $clog2(SYNC_TO + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic clr,
  output logic in_win,
  output logic late
);
  localparam logic [W:0] LO = (W+1)'(SPB - WIN);
  localparam logic [W:0] HI = (W+1)'(SPB + WIN);
  logic [W-1:0] cnt;
  logic [W:0]   tick;
  // tick is the 1-based count of the enb cycle currently being presented
  assign tick   = {1'b0, cnt} + 1'b1;
  assign in_win = tick >= LO && tick <= HI;
  assign late   = tick > HI;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (enb) cnt <= clr ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mx_frame_rx.sv
// mx_frame_rx: Manchester frame receiver FSM turning correlator hits into bytes, eof and error pulses
module mx_frame_rx import mx_rx_pkg::*; #(
  parameter int SPB     = DEF_SPB,
  parameter int WIN     = DEF_WIN,
  parameter int SYNC_TO = DEF_SYNC_TO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       pre_h,
  input  logic       sfd_h,
  input  logic       bit_h,
  input  logic       bit_l,
  input  logic       eof_h,
  output logic [7:0] data,
  output logic       valid,
  output logic       cardet,
  output logic       eof,
  output logic       error
);
  state_t     state, nxt;
  logic [7:0] shreg, sh_nxt;
  logic [2:0] bcnt;
  logic       in_win, late, s_hit, s_late;
  logic       dec, late_ev, eof_ev, err_ev, sto;
  mx_bit_timer #(.SPB(SPB), .WIN(WIN), .SYNC_TO(SYNC_TO)) u_bit (
    .clk(clk), .rst(rst), .enb(enb), .clr(state != DATA || dec), .in_win(in_win), .late(late)
  );
  // sync timeout reuses the timer with a zero-width window centred on SYNC_TO
  mx_bit_timer #(.SPB(SYNC_TO), .WIN(0), .SYNC_TO(SYNC_TO)) u_sync (
    .clk(clk), .rst(rst), .enb(enb), .clr(state != SYNC), .in_win(s_hit), .late(s_late)
  );
  always_comb begin
    sto     = s_hit || s_late;
    sh_nxt  = {bit_h, shreg[7:1]};
    dec     = enb && state == DATA && in_win && (bit_h || bit_l);
    late_ev = enb && state == DATA && late && !dec;
    eof_ev  = late_ev && eof_h && bcnt == 3'd0;
    err_ev  = (late_ev && !eof_ev) || (enb && state == SYNC && !sfd_h && sto);
    nxt     = state;
    if (enb)
      nxt = state == IDLE ? (pre_h ? SYNC : IDLE) :
            state == SYNC ? (sfd_h ? DATA : sto ? IDLE : SYNC) :
            (late ? IDLE : DATA);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      bcnt   <= '0;
      data   <= '0;
      valid  <= 1'b0;
      cardet <= 1'b0;
      eof    <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= nxt;
      valid  <= dec && bcnt == 3'd7;
      eof    <= eof_ev;
      error  <= err_ev;
      cardet <= nxt == DATA;
      if (state != DATA) begin
        shreg <= '0;
        bcnt  <= '0;
      end else if (dec) begin
        shreg <= sh_nxt;
        bcnt  <= bcnt + 1'b1;
        if (bcnt == 3'd7) data <= sh_nxt;
      end
    end
endmodule
